// File: rtl/egress_arbiter_if.sv
// egress_arbiter_if: FIFO-drain inputs, pop strobes and tagged egress/status bundle for egress_arbiter
interface egress_arbiter_if #(parameter int data_width = 6, parameter int cnt_width = 8);
  logic [data_width-1:0] data_out_D0, data_out_D1, data_out;
  logic empty_fifo_D0, empty_fifo_D1, active_out, error_out, ready_in;
  logic D0_pop, D1_pop, valid_out, src_out, drained;
  logic [cnt_width-1:0] count_D0, count_D1;
  modport master (
    input data_out_D0, data_out_D1, empty_fifo_D0, empty_fifo_D1, active_out, error_out, ready_in,
    output D0_pop, D1_pop, data_out, valid_out, src_out, count_D0, count_D1, drained
  );
  modport slave (
    output data_out_D0, data_out_D1, empty_fifo_D0, empty_fifo_D1, active_out, error_out, ready_in,
    input D0_pop, D1_pop, data_out, valid_out, src_out, count_D0, count_D1, drained
  );
endinterface

// File: rtl/egress_arbiter.sv
// egress_arbiter: round-robin drain of D0/D1 FIFOs onto a source-tagged valid/ready egress port
module egress_arbiter #(
  parameter int data_width = 6,
  parameter int cnt_width = 8
) (
  input logic clk,
  input logic reset,
  egress_arbiter_if.master bus
);
  logic [data_width:0] ent [2];
  logic [1:0] occ;
  logic inflight, inflight_src, last_grant, xfer, issue, grant, pop, wr_idx, drained_q;
  logic [cnt_width-1:0] cnt0, cnt1;
  always_comb begin
    xfer = (occ != 2'd0) && bus.ready_in;
    wr_idx = occ[1] || (occ[0] && !xfer);
    issue = bus.active_out && !bus.error_out &&
            (({1'b0, occ} + {2'b0, inflight} - {2'b0, xfer}) < 3'd2);
    grant = (!bus.empty_fifo_D0 && !bus.empty_fifo_D1) ? !last_grant : !bus.empty_fifo_D1;
    pop = issue && !(bus.empty_fifo_D0 && bus.empty_fifo_D1);
  end
  assign bus.D0_pop = pop && !grant;
  assign bus.D1_pop = pop && grant;
  assign bus.data_out = ent[0][data_width-1:0];
  assign bus.src_out = ent[0][data_width];
  assign bus.valid_out = occ != 2'd0;
  assign bus.count_D0 = cnt0;
  assign bus.count_D1 = cnt1;
  assign bus.drained = drained_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent[0] <= '0;
      ent[1] <= '0;
      occ <= '0;
      inflight <= 1'b0;
      inflight_src <= 1'b0;
      last_grant <= 1'b1;
      cnt0 <= '0;
      cnt1 <= '0;
      drained_q <= 1'b1;
    end else begin
      if (xfer) ent[0] <= ent[1];
      if (inflight) ent[wr_idx] <= {inflight_src, inflight_src ? bus.data_out_D1 : bus.data_out_D0};
      occ <= occ + {1'b0, inflight} - {1'b0, xfer};
      inflight <= pop;
      inflight_src <= grant;
      if (pop) last_grant <= grant;
      if (xfer && !ent[0][data_width]) cnt0 <= cnt0 + cnt_width'(1);
      if (xfer && ent[0][data_width]) cnt1 <= cnt1 + cnt_width'(1);
      drained_q <= bus.empty_fifo_D0 && bus.empty_fifo_D1 && !inflight && occ == 2'd0;
    end
  end
endmodule

// File: tb/tb_egress_arbiter.sv
// tb_egress_arbiter: table vectors, directed corner sequences and a random run against a word-level model
module tb_egress_arbiter;
  logic clk = 1'b0;
  logic reset;
  egress_arbiter_if #(.data_width(6), .cnt_width(8)) dif();
  egress_arbiter #(.data_width(6), .cnt_width(8)) dut (.clk(clk), .reset(reset), .bus(dif));
  always #5 clk = ~clk;
  logic [5:0] mem [2][4096];
  int pushed [2] = '{0, 0};
  int popped [2];
  int vectors = 0, miscompares = 0;
  assign dif.empty_fifo_D0 = pushed[0] == popped[0];
  assign dif.empty_fifo_D1 = pushed[1] == popped[1];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      popped[0] <= pushed[0];
      popped[1] <= pushed[1];
      dif.data_out_D0 <= '0;
      dif.data_out_D1 <= '0;
    end else begin
      if (dif.D0_pop) begin
        dif.data_out_D0 <= mem[0][popped[0] % 4096];
        popped[0] <= popped[0] + 1;
      end
      if (dif.D1_pop) begin
        dif.data_out_D1 <= mem[1][popped[1] % 4096];
        popped[1] <= popped[1] + 1;
      end
    end
  end
  typedef struct packed {logic s; logic [5:0] d;} ent_t;
  ent_t pend[$];
  bit lp = 1'b0, lg = 1'b1, dr_e = 1'b1, ne0, ne1, xf, pe, g;
  logic [7:0] m0 = '0, m1 = '0;
  int occ_m;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic push(input logic s, input logic [5:0] d);
    mem[s][pushed[s] % 4096] = d;
    pushed[s]++;
  endtask
  task automatic set(input bit a, input bit e, input bit r);
    dif.active_out = a;
    dif.error_out = e;
    dif.ready_in = r;
  endtask
  task automatic model();
    if (reset) begin
      pend.delete();
      lp = 1'b0;
      lg = 1'b1;
      m0 = '0;
      m1 = '0;
      dr_e = 1'b1;
    end else begin
      ne0 = pushed[0] != popped[0];
      ne1 = pushed[1] != popped[1];
      occ_m = pend.size() - int'(lp);
      xf = occ_m > 0 && dif.ready_in;
      pe = dif.active_out && !dif.error_out && (pend.size() - int'(xf)) < 2 && (ne0 || ne1);
      g = (ne0 && ne1) ? !lg : ne1;
      chk("pop", {dif.D0_pop, dif.D1_pop}, pe ? {!g, g} : 2'b00);
      chk("valid", dif.valid_out, occ_m > 0);
      if (occ_m > 0) begin
        chk("data", dif.data_out, pend[0].d);
        chk("src", dif.src_out, pend[0].s);
      end
      chk("count_D0", dif.count_D0, m0);
      chk("count_D1", dif.count_D1, m1);
      chk("drained", dif.drained, dr_e);
      dr_e = !ne0 && !ne1 && pend.size() == 0;
      if (xf) begin
        if (pend[0].s) m1++;
        else m0++;
        void'(pend.pop_front());
      end
      if (pe) begin
        pend.push_back('{g, mem[g][popped[g] % 4096]});
        lg = g;
      end
      lp = pe;
    end
  endtask
  task automatic tick();
    @(negedge clk);
    model();
    @(posedge clk);
    #1;
  endtask
  typedef struct {
    logic [6:0] p0, p1;
    bit a, e, r, ep0, ep1, ev;
    logic [5:0] ed;
    bit es;
    logic [7:0] ec0, ec1;
    bit edr;
  } vec_t;
  vec_t tv [14];
  int np, base;
  initial begin
    tv[0]  = '{7'h41, 7'h61, 0, 0, 1, 0, 0, 0, 6'h00, 0, 0, 0, 1};
    tv[1]  = '{7'h42, 7'h62, 0, 0, 1, 0, 0, 0, 6'h00, 0, 0, 0, 0};
    tv[2]  = '{7'h00, 7'h00, 1, 0, 1, 1, 0, 0, 6'h00, 0, 0, 0, 0};
    tv[3]  = '{7'h00, 7'h00, 1, 0, 1, 0, 1, 0, 6'h00, 0, 0, 0, 0};
    tv[4]  = '{7'h00, 7'h00, 1, 0, 1, 1, 0, 1, 6'h01, 0, 0, 0, 0};
    tv[5]  = '{7'h00, 7'h00, 1, 0, 1, 0, 1, 1, 6'h21, 1, 1, 0, 0};
    tv[6]  = '{7'h00, 7'h00, 1, 0, 1, 0, 0, 1, 6'h02, 0, 1, 1, 0};
    tv[7]  = '{7'h00, 7'h00, 1, 0, 1, 0, 0, 1, 6'h22, 1, 2, 1, 0};
    tv[8]  = '{7'h00, 7'h00, 1, 0, 1, 0, 0, 0, 6'h00, 0, 2, 2, 0};
    tv[9]  = '{7'h55, 7'h00, 1, 0, 1, 1, 0, 0, 6'h00, 0, 2, 2, 1};
    tv[10] = '{7'h00, 7'h00, 1, 0, 1, 0, 0, 0, 6'h00, 0, 2, 2, 0};
    tv[11] = '{7'h00, 7'h00, 1, 0, 1, 0, 0, 1, 6'h15, 0, 2, 2, 0};
    tv[12] = '{7'h00, 7'h00, 1, 0, 1, 0, 0, 0, 6'h00, 0, 3, 2, 0};
    tv[13] = '{7'h00, 7'h00, 1, 0, 1, 0, 0, 0, 6'h00, 0, 3, 2, 1};
    reset = 1'b1;
    set(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", dif.valid_out, 0);
    chk("rst_data", dif.data_out, 0);
    chk("rst_src", dif.src_out, 0);
    chk("rst_counts", {dif.count_D0, dif.count_D1}, 0);
    chk("rst_drained", dif.drained, 1);
    chk("rst_pops", {dif.D0_pop, dif.D1_pop}, 0);
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (tv[i].p0[6]) push(0, tv[i].p0[5:0]);
      if (tv[i].p1[6]) push(1, tv[i].p1[5:0]);
      set(tv[i].a, tv[i].e, tv[i].r);
      #1;
      chk("tv_pops", {dif.D0_pop, dif.D1_pop}, {tv[i].ep0, tv[i].ep1});
      chk("tv_valid", dif.valid_out, tv[i].ev);
      if (tv[i].ev) chk("tv_word", {dif.src_out, dif.data_out}, {tv[i].es, tv[i].ed});
      chk("tv_counts", {dif.count_D0, dif.count_D1}, {tv[i].ec0, tv[i].ec1});
      chk("tv_drained", dif.drained, tv[i].edr);
      tick();
    end
    set(1, 0, 0);
    for (int i = 0; i < 5; i++) push(0, 6'(48 + i));
    np = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      np += int'(dif.D0_pop);
      if (c >= 3) chk("bp_head", {dif.valid_out, dif.data_out}, {1'b1, 6'h30});
      tick();
    end
    chk("bp_pops", np, 2);
    set(1, 0, 1);
    repeat (12) tick();
    chk("bp_count", dif.count_D0, 8);
    base = popped[1];
    for (int i = 0; i < 6; i++) push(1, 6'(32 + i));
    set(1, 0, 1);
    repeat (3) tick();
    set(1, 1, 1);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("err_nopop", dif.D1_pop, 0);
      tick();
    end
    chk("err_pops", popped[1] - base, 3);
    chk("err_count", dif.count_D1, 2 + popped[1] - base);
    set(1, 0, 1);
    repeat (10) tick();
    chk("err_drain_count", dif.count_D1, 8);
    set(1, 0, 0);
    for (int i = 0; i < 4; i++) push(0, 6'(16 + i));
    repeat (4) tick();
    chk("pre_rst_valid", dif.valid_out, 1);
    reset = 1'b1;
    #1;
    chk("arst_valid", dif.valid_out, 0);
    chk("arst_data", dif.data_out, 0);
    chk("arst_counts", {dif.count_D0, dif.count_D1}, 0);
    chk("arst_drained", dif.drained, 1);
    chk("arst_pops", {dif.D0_pop, dif.D1_pop}, 0);
    repeat (2) tick();
    reset = 1'b0;
    set(1, 0, 1);
    for (int i = 0; i < 256; i++) push(0, 6'($urandom));
    repeat (270) tick();
    chk("wrap_count", dif.count_D0, 0);
    push(0, 6'h3f);
    repeat (5) tick();
    chk("wrap_plus1", dif.count_D0, 1);
    repeat (600) begin
      if ($urandom_range(0, 2) == 0) push(1'($urandom_range(0, 1)), 6'($urandom));
      set($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
      tick();
    end
    set(1, 0, 1);
    repeat (20) tick();
    chk("final_drained", dif.drained, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
